// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if
// Groups the command channel (software arm/disarm requests) and the fired
// channel (expired-slot notifications) of the timer scheduler.
//   cmd_valid/cmd_ready    : command handshake, accepted when both are high
//   cmd_arm                : 1 = arm cmd_slot with cmd_deadline, 0 = disarm it
//   cmd_slot/cmd_deadline  : target slot and absolute 64-bit mtime deadline
//   fired_valid/fired_slot : an armed slot's deadline has been reached
//   fired_ack              : consumer has taken the fired slot
// master = the software/consumer side, slave = the scheduler.
interface timer_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_arm;
  logic [1:0]  cmd_slot;
  logic [63:0] cmd_deadline;
  logic        fired_valid;
  logic [1:0]  fired_slot;
  logic        fired_ack;

  modport master (
    output cmd_valid, cmd_arm, cmd_slot, cmd_deadline, fired_ack,
    input  cmd_ready, fired_valid, fired_slot
  );

  modport slave (
    input  cmd_valid, cmd_arm, cmd_slot, cmd_deadline, fired_ack,
    output cmd_ready, fired_valid, fired_slot
  );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler
// Multiplexes four software deadline slots onto one hardware mtimecmp
// comparator. After every change it scans the armed slots for the earliest
// deadline and programs mtimecmp with it (high word parked at all-ones first so
// the timer cannot fire on a half-written value). When the timer interrupt
// shows the selected deadline reached, the slot is reported on the fired
// channel until acknowledged, then disarmed and the scan repeats.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cmd_if (slave)      : command and fired channels
//   mtime               : current timer count
//   timer_irq           : timer interrupt (mtime >= mtimecmp)
//   timer_write_enable  : one-cycle write strobe to the timer registers
//   timer_address       : timer register address for the strobe
//   timer_write_data    : timer register data for the strobe
//   armed_mask          : bit i = slot i armed
//
// state     | meaning
// ----------+---------------------------------------------------------
// SCAN      | pick earliest armed deadline into target/sel
// WR_HI_MAX | write mtimecmp high = all-ones (park)
// WR_LO     | write mtimecmp low  = target[31:0]
// WR_HI     | write mtimecmp high = target[63:32]
// ARMED     | idle: accept commands, watch for the selected deadline
// FIRE      | report sel on the fired channel until acknowledged
module timer_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h40004000,
  parameter int          NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_scheduler_if.slave     cmd_if,
  input  logic [63:0]          mtime,
  input  logic                 timer_irq,
  output logic                 timer_write_enable,
  output logic [31:0]          timer_address,
  output logic [31:0]          timer_write_data,
  output logic [NUM_SLOTS-1:0] armed_mask
);

  localparam logic [31:0] ADDR_CMP_LO = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_CMP_HI = BASE_ADDR + 32'hC;

  typedef enum logic [2:0] {
    SCAN,
    WR_HI_MAX,
    WR_LO,
    WR_HI,
    ARMED,
    FIRE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   armed_q, armed_d;
  logic [63:0]            deadline_q [NUM_SLOTS];
  logic [63:0]            target_q, target_d;
  logic [1:0]             sel_q, sel_d;

  logic [63:0]            scan_min;
  logic [1:0]             scan_idx;
  logic                   scan_any;
  logic                   fire_hit;
  logic                   dl_we;
  logic                   ready;
  logic                   fire_out;
  logic                   we;
  logic [31:0]            addr;
  logic [31:0]            wdata;

  // Earliest armed deadline; strict '<' keeps the lowest index on ties.
  // With nothing armed the defaults leave target all-ones and sel 0.
  always_comb begin
    scan_min = '1;
    scan_idx = '0;
    scan_any = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (armed_q[i] && (!scan_any || (deadline_q[i] < scan_min))) begin
        scan_min = deadline_q[i];
        scan_idx = 2'(i);
        scan_any = 1'b1;
      end
    end
  end

  // The irq alone is not trusted: the selected slot must still be armed and
  // its own deadline reached.
  assign fire_hit = timer_irq && armed_q[sel_q] && (mtime >= deadline_q[sel_q]);

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    target_d = target_q;
    sel_d    = sel_q;
    dl_we    = 1'b0;
    ready    = 1'b0;
    fire_out = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    case (state_q)
      SCAN: begin
        target_d = scan_min;
        sel_d    = scan_idx;
        state_d  = WR_HI_MAX;
      end
      WR_HI_MAX: begin
        we      = 1'b1;
        addr    = ADDR_CMP_HI;
        wdata   = '1;
        state_d = WR_LO;
      end
      WR_LO: begin
        we      = 1'b1;
        addr    = ADDR_CMP_LO;
        wdata   = target_q[31:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        we      = 1'b1;
        addr    = ADDR_CMP_HI;
        wdata   = target_q[63:32];
        state_d = ARMED;
      end
      ARMED: begin
        if (fire_hit) begin
          state_d = FIRE;
        end else begin
          ready = 1'b1;
          if (cmd_if.cmd_valid && !rst) begin
            armed_d[cmd_if.cmd_slot] = cmd_if.cmd_arm;
            dl_we   = cmd_if.cmd_arm;
            state_d = SCAN;
          end
        end
      end
      FIRE: begin
        fire_out = 1'b1;
        if (cmd_if.fired_ack) begin
          armed_d[sel_q] = 1'b0;
          state_d        = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      armed_q  <= '0;
      target_q <= '1;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      target_q <= target_d;
      sel_q    <= sel_d;
    end
  end

  // Deadlines are only meaningful while their armed bit is set, so they need
  // no reset.
  always_ff @(posedge clk) begin
    if (dl_we) begin
      deadline_q[cmd_if.cmd_slot] <= cmd_if.cmd_deadline;
    end
  end

  // Outputs are forced quiet combinationally so reset silences them in the
  // same cycle it is raised, not one edge later.
  assign cmd_if.cmd_ready   = ready && !rst;
  assign cmd_if.fired_valid = fire_out && !rst;
  assign cmd_if.fired_slot  = (fire_out && !rst) ? sel_q : 2'd0;
  assign timer_write_enable = we && !rst;
  assign timer_address      = rst ? 32'd0 : addr;
  assign timer_write_data   = rst ? 32'd0 : wdata;
  assign armed_mask         = rst ? '0 : armed_q;

endmodule
